id_decode: RTL
==============

Name: id_decode

Overview:
- Instruction-decode stage, the consumer end of the fetch interface.
- Latches each instruction and its PC presented by fetch, reads the register file, and decodes the instruction into an EX-stage pipeline register.
- Drives the fetch control inputs back to fetch: IsStall, IsBranch, BranchAddr.
- Resolves branches in ID with a one-bubble squash. Detects load-use and branch-operand hazards and stalls on them.

Parameters:
- WIDTH, 32: datapath/instruction width. PC and BranchAddr are WIDTH-2 bits, byte addresses, 4-aligned.
- RA, 5: register address width. 2^RA registers; r0 reads zero.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_ins  in  WIDTH  instruction from fetch
- if_pc  in  WIDTH-2  PC of if_ins
- if_valid  in  1  if_ins is a real instruction
- IsStall  out  1  fetch holds PC; combinational
- IsBranch  out  1  fetch loads BranchAddr; combinational
- BranchAddr  out  WIDTH-2  branch target; combinational
- rs_a_addr  out  RA  register file read port A address
- rs_b_addr  out  RA  register file read port B address
- rs_a_data  in  WIDTH  read port A data; combinational, write-first bypass from WB
- rs_b_data  in  WIDTH  read port B data; same timing as port A
- mem_we  in  1  MEM-stage instruction writes a register
- mem_rd  in  RA  MEM-stage destination register
- ex_valid  out  1  EX register holds a real instruction
- ex_op  out  6  opcode
- ex_rd  out  RA  destination register
- ex_a  out  WIDTH  operand A value
- ex_b  out  WIDTH  operand B value
- ex_imm  out  WIDTH  sign-extended imm16
- ex_we  out  1  EX instruction writes a register
- ex_mem_rd  out  1  EX instruction is a load
- ex_mem_wr  out  1  EX instruction is a store
- id_illegal  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Instruction format: op [31:26], rd [25:21], rs1 [20:16], rs2 [15:11], imm16 [15:0], imm26 [25:0].
- Opcodes:
  - 0x00 NOP
  - 0x01 ADD, 0x02 SUB, 0x03 AND, 0x04 OR: R-type; sources rs1, rs2; we=1
  - 0x08 ADDI: source rs1; we=1
  - 0x10 LW: source rs1; we=1, mem_rd=1
  - 0x11 SW: sources rs1 (base), rd (data); mem_wr=1
  - 0x20 BEQ, 0x21 BNE: compare reg[rd] with reg[rs1]
  - 0x22 JMP: no sources
- Any other opcode decodes as NOP, with id_illegal=1 for the cycle the instruction is in ID.
- Read addresses:
  - rs_a_addr = rs1 always.
  - rs_b_addr = rs2 for R-type; rd for SW, BEQ, BNE.
  - Register 0 is never a hazard source or destination.
- ID register (id_valid, id_ins, id_pc), updated on each rising edge:
  - IsStall=1: hold.
  - Otherwise load if_ins and if_pc; id_valid <= if_valid & ~IsBranch. The fall-through fetched during a taken branch is squashed.
- EX register, updated on each rising edge:
  - IsStall=1 or id_valid=0: bubble. ex_valid=0 and ex_we=ex_mem_rd=ex_mem_wr=0; other fields don't-care.
  - Otherwise load the decoded fields. ex_a=rs_a_data, ex_b=rs_b_data.
- Hazards (all combinational from the ID and EX registers plus mem_*); IsStall=1 when id_valid and any of:
  - Load-use: ex_valid & ex_mem_rd & ex_rd≠0 & ex_rd matches a used source.
  - Branch/EX: ID op is BEQ/BNE & ex_valid & ex_we & ex_rd≠0 & ex_rd matches a source.
  - Branch/MEM: ID op is BEQ/BNE & mem_we & mem_rd≠0 & mem_rd matches a source.
- Branch resolution:
  - IsBranch = id_valid & ~IsStall & (JMP | BEQ with equal values | BNE with unequal values).
  - Target = id_pc + 4 + (sext(imm) << 2). imm is imm16 for BEQ/BNE and imm26 for JMP. Truncate to WIDTH-2 bits; wrap-around is allowed.
  - BranchAddr shows the target whenever IsBranch=1, otherwise 0.
  - A taken branch still enters EX as a non-writing instruction (ex_valid=1, ex_we=0).
- Simultaneous events: stall has priority over branch; a branch is never taken while stalled.
- Reset (asynchronous, any time, including mid-stall): id_valid=0, ex_valid=0, all ex_* = 0, id_illegal=0. Outputs are then IsStall=0, IsBranch=0, BranchAddr=0.
- Latency: one cycle from ID register to EX register. Taken-branch penalty is one bubble.

Test Plan:
- Reset: hold rst_n=0, then release -> ex_valid=0, IsStall=0, IsBranch=0, BranchAddr=0, id_illegal=0.
- ADD r3,r1,r2 with rs_a_data=5, rs_b_data=7 -> next edge: ex_valid=1, ex_op=0x01, ex_rd=3, ex_a=5, ex_b=7, ex_we=1.
- LW r4 followed by ADD r5,r4,r1 -> IsStall=1 for exactly one cycle; one EX bubble; ADD reaches EX one cycle later. The same sequence with LW r0 -> no stall.
- BEQ r1,r2 at id_pc=0x40, imm16=3, equal data -> IsBranch=1, BranchAddr=0x50. The next if_ins is squashed (ex_valid=0 two edges later). With unequal data -> IsBranch=0, no bubble.
- ADDI r1 then BEQ r1,r2 with mem_we/mem_rd following the pipeline -> 2 stall cycles (EX match, then MEM match), then the branch resolves.
- Assert rst_n=0 mid-stall, asynchronously between edges -> IsStall and ex_valid drop immediately. After release, decode restarts cleanly from the next if_ins.

Source files
------------

// File: rtl/id_decode_if.sv
// Fetch <-> decode interface. Fetch (master) presents an instruction and
// its PC; decode (slave) answers with stall and branch-redirect controls.
interface id_decode_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] if_ins;
  logic [WIDTH-3:0] if_pc;
  logic             if_valid;
  logic             IsStall;
  logic             IsBranch;
  logic [WIDTH-3:0] BranchAddr;

  modport master (
    output if_ins, if_pc, if_valid,
    input  IsStall, IsBranch, BranchAddr
  );

  modport slave (
    input  if_ins, if_pc, if_valid,
    output IsStall, IsBranch, BranchAddr
  );
endinterface

// File: rtl/id_decode.sv
// Instruction-decode stage. Holds the ID pipeline register, reads the
// register file, resolves branches with a one-bubble squash, detects
// load-use and branch-operand hazards, and fills the EX pipeline register.
module id_decode #(
  parameter int WIDTH = 32,
  parameter int RA    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  id_decode_if.slave       fetch,
  output logic [RA-1:0]    rs_a_addr,
  output logic [RA-1:0]    rs_b_addr,
  input  logic [WIDTH-1:0] rs_a_data,
  input  logic [WIDTH-1:0] rs_b_data,
  input  logic             mem_we,
  input  logic [RA-1:0]    mem_rd,
  output logic             ex_valid,
  output logic [5:0]       ex_op,
  output logic [RA-1:0]    ex_rd,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_imm,
  output logic             ex_we,
  output logic             ex_mem_rd,
  output logic             ex_mem_wr,
  output logic             id_illegal
);

  localparam int PW = WIDTH - 2;
  localparam logic [PW-1:0] PC_STEP = PW'(4);

  typedef enum logic [5:0] {
    OP_NOP  = 6'h00,
    OP_ADD  = 6'h01,
    OP_SUB  = 6'h02,
    OP_AND  = 6'h03,
    OP_OR   = 6'h04,
    OP_ADDI = 6'h08,
    OP_LW   = 6'h10,
    OP_SW   = 6'h11,
    OP_BEQ  = 6'h20,
    OP_BNE  = 6'h21,
    OP_JMP  = 6'h22
  } opcode_e;

  logic             id_valid_q, id_valid_d;
  logic [WIDTH-1:0] id_ins_q, id_ins_d;
  logic [PW-1:0]    id_pc_q, id_pc_d;

  logic             ex_valid_q, ex_valid_d;
  logic [5:0]       ex_op_q, ex_op_d;
  logic [RA-1:0]    ex_rd_q, ex_rd_d;
  logic [WIDTH-1:0] ex_a_q, ex_a_d;
  logic [WIDTH-1:0] ex_b_q, ex_b_d;
  logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic             ex_we_q, ex_we_d;
  logic             ex_mem_rd_q, ex_mem_rd_d;
  logic             ex_mem_wr_q, ex_mem_wr_d;

  logic [5:0]    op, dec_op;
  logic [RA-1:0] rd, rs1, rs2;
  logic          use_a, use_b, b_from_rd;
  logic          dec_we, dec_ld, dec_st;
  logic          is_beq, is_bne, is_jmp, illegal;

  logic          hit_ex, hit_mem, is_br, operands_eq, taken;
  logic          stall, branch, issue;
  logic [PW-1:0] offset, target;

  // Decode the instruction held in ID: which sources it reads and what it does.
  always_comb begin
    op        = id_ins_q[31:26];
    rd        = id_ins_q[21 +: RA];
    rs1       = id_ins_q[16 +: RA];
    rs2       = id_ins_q[11 +: RA];
    dec_op    = op;
    use_a     = 1'b0;
    use_b     = 1'b0;
    b_from_rd = 1'b0;
    dec_we    = 1'b0;
    dec_ld    = 1'b0;
    dec_st    = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_jmp    = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        use_a  = 1'b1;
        use_b  = 1'b1;
        dec_we = 1'b1;
      end
      OP_ADDI: begin
        use_a  = 1'b1;
        dec_we = 1'b1;
      end
      OP_LW: begin
        use_a  = 1'b1;
        dec_we = 1'b1;
        dec_ld = 1'b1;
      end
      OP_SW: begin
        use_a     = 1'b1;
        use_b     = 1'b1;
        b_from_rd = 1'b1;
        dec_st    = 1'b1;
      end
      OP_BEQ: begin
        use_a     = 1'b1;
        use_b     = 1'b1;
        b_from_rd = 1'b1;
        is_beq    = 1'b1;
      end
      OP_BNE: begin
        use_a     = 1'b1;
        use_b     = 1'b1;
        b_from_rd = 1'b1;
        is_bne    = 1'b1;
      end
      OP_JMP: is_jmp = 1'b1;
      default: begin
        illegal = 1'b1;
        dec_op  = OP_NOP;
      end
    endcase
    rs_a_addr = rs1;
    rs_b_addr = b_from_rd ? rd : rs2;
  end

  // Hazard detection and branch resolution; a stall always suppresses the branch.
  always_comb begin
    hit_ex  = (ex_rd_q != '0) &
              ((use_a & (rs_a_addr == ex_rd_q)) | (use_b & (rs_b_addr == ex_rd_q)));
    hit_mem = (mem_rd != '0) &
              ((use_a & (rs_a_addr == mem_rd)) | (use_b & (rs_b_addr == mem_rd)));
    is_br   = is_beq | is_bne;
    stall   = id_valid_q & ((ex_valid_q & ex_mem_rd_q & hit_ex) |
                            (is_br & ex_valid_q & ex_we_q & hit_ex) |
                            (is_br & mem_we & hit_mem));
    operands_eq = (rs_a_data == rs_b_data);
    taken   = is_jmp | (is_beq & operands_eq) | (is_bne & ~operands_eq);
    branch  = id_valid_q & ~stall & taken;
    if (is_jmp)
      offset = {{(PW-28){id_ins_q[25]}}, id_ins_q[25:0], 2'b00};
    else
      offset = {{(PW-18){id_ins_q[15]}}, id_ins_q[15:0], 2'b00};
    target  = id_pc_q + PC_STEP + offset;
    fetch.IsStall    = stall;
    fetch.IsBranch   = branch;
    fetch.BranchAddr = branch ? target : '0;
    id_illegal       = id_valid_q & illegal;
  end

  // Next values for the ID and EX registers: hold ID on stall, bubble EX on stall or empty ID.
  always_comb begin
    id_valid_d = id_valid_q;
    id_ins_d   = id_ins_q;
    id_pc_d    = id_pc_q;
    if (!stall) begin
      id_valid_d = fetch.if_valid & ~branch;
      id_ins_d   = fetch.if_ins;
      id_pc_d    = fetch.if_pc;
    end
    issue       = id_valid_q & ~stall;
    ex_valid_d  = issue;
    ex_we_d     = issue & dec_we;
    ex_mem_rd_d = issue & dec_ld;
    ex_mem_wr_d = issue & dec_st;
    ex_op_d     = dec_op;
    ex_rd_d     = rd;
    ex_a_d      = rs_a_data;
    ex_b_d      = rs_b_data;
    ex_imm_d    = {{(WIDTH-16){id_ins_q[15]}}, id_ins_q[15:0]};
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid_q  <= 1'b0;
      id_ins_q    <= '0;
      id_pc_q     <= '0;
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_rd_q     <= '0;
      ex_a_q      <= '0;
      ex_b_q      <= '0;
      ex_imm_q    <= '0;
      ex_we_q     <= 1'b0;
      ex_mem_rd_q <= 1'b0;
      ex_mem_wr_q <= 1'b0;
    end else begin
      id_valid_q  <= id_valid_d;
      id_ins_q    <= id_ins_d;
      id_pc_q     <= id_pc_d;
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_rd_q     <= ex_rd_d;
      ex_a_q      <= ex_a_d;
      ex_b_q      <= ex_b_d;
      ex_imm_q    <= ex_imm_d;
      ex_we_q     <= ex_we_d;
      ex_mem_rd_q <= ex_mem_rd_d;
      ex_mem_wr_q <= ex_mem_wr_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op     = ex_op_q;
  assign ex_rd     = ex_rd_q;
  assign ex_a      = ex_a_q;
  assign ex_b      = ex_b_q;
  assign ex_imm    = ex_imm_q;
  assign ex_we     = ex_we_q;
  assign ex_mem_rd = ex_mem_rd_q;
  assign ex_mem_wr = ex_mem_wr_q;

endmodule
